// File: rtl/odd_parity_tx_pkg.sv
// Shared types and constants for the odd-parity serial transmitter.
//   tx_state_t : frame sequencer states
//   LINE_IDLE  : level driven on the serial line between frames
//   START_BIT  : level of the frame start bit
//   STOP_BIT   : level of the frame stop bit
//   cnt_width  : width of a counter spanning 0..n-1, never less than 1
package odd_parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator.
//   data   in  WIDTH  word to protect
//   parity out 1      bit that makes the total count of ones (data + parity) odd
module odd_parity_gen #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ~^data;

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Serial transmitter that frames each accepted word as
//   start bit, data LSB-first, odd parity bit, stop bit,
// holding every bit on the line for CLKS_PER_BIT clocks.
//   clk        in  1      clock, all state changes on the rising edge
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      upstream word valid
//   in_ready   out 1      word can be accepted (only while idle)
//   in_data    in  WIDTH  word to transmit
//   tx_serial  out 1      serial line, high when idle
//   tx_busy    out 1      a frame is in progress
//   frame_done out 1      one-cycle pulse in the first idle cycle after a stop bit
module odd_parity_serial_tx
    import odd_parity_tx_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             tx_serial,
    output logic             tx_busy,
    output logic             frame_done
);

    localparam int BIT_W  = cnt_width(WIDTH);
    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t          state;
    tx_state_t          state_next;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BAUD_W-1:0]  baud_next;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_next;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;
    logic               par;
    logic               par_next;
    logic               par_in;
    logic               tx_next;
    logic               done_next;
    logic               baud_end;

    odd_parity_gen #(
        .WIDTH (WIDTH)
    ) u_parity (
        .data   (in_data),
        .parity (par_in)
    );

    assign in_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign baud_end = (baud_cnt == BAUD_LAST);

    // With one clock per bit every cycle ends a bit period, so the baud
    // counter collapses to a constant zero.
    generate
        if (CLKS_PER_BIT == 1) begin : g_no_baud
            assign baud_cnt = '0;
        end else begin : g_baud
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    baud_cnt <= '0;
                end else begin
                    baud_cnt <= baud_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tx_serial  <= LINE_IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_next;
            shreg      <= shreg_next;
            par        <= par_next;
            tx_serial  <= tx_next;
            frame_done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        par_next   = par;
        done_next  = 1'b0;

        // The baud counter runs freely in every active state and restarts
        // at each bit boundary; IDLE keeps it parked at zero.
        if (state != IDLE) begin
            baud_next = baud_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (in_valid) begin
                    shreg_next = in_data;
                    par_next   = par_in;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_next   = '0;
                        state_next = PARITY;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The line is registered: its next level follows the state being
    // entered, so the start bit appears the cycle right after accept.
    always_comb begin
        tx_next = LINE_IDLE;
        case (state_next)
            IDLE:    tx_next = LINE_IDLE;
            START:   tx_next = START_BIT;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = par_next;
            STOP:    tx_next = STOP_BIT;
            default: tx_next = LINE_IDLE;
        endcase
    end

endmodule
